// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack data-memory transaction per
// access, stalls the pipeline while it is outstanding and formats load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_valid,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_DMType,
    input  logic [31:0] MEM_aluout,
    input  logic [31:0] MEM_rs2data,
    input  logic        INT_detected,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] MEM_Data_in,
    output logic        mem_stall,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state, state_nx;
    logic             access, misaligned, start, timeout_hit;
    logic [1:0]       size;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       type_q;
    logic [1:0]       lo_q;
    logic             err_q;
    logic [31:0]      data_q;

    // Access size; undefined type codes fall back to word.
    function automatic logic [1:0] size_of(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: size_of = SZ_HALF;
            3'b011, 3'b100: size_of = SZ_BYTE;
            default:        size_of = SZ_WORD;
        endcase
    endfunction

    // Select the lane(s) of the read word and extend to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [2:0] t, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> {lo, 3'b000};
        h  = lo[1] ? w[31:16] : w[15:0];
        case (t)
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b010:  fmt_load = {16'h0000, h};
            3'b011:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            3'b100:  fmt_load = {24'h000000, sh[7:0]};
            default: fmt_load = w;
        endcase
    endfunction

    assign access      = MEM_valid & (MEM_MemRead | MEM_MemWrite);
    assign size        = size_of(MEM_DMType);
    assign misaligned  = ((size == SZ_WORD) && (MEM_aluout[1:0] != 2'b00)) ||
                         ((size == SZ_HALF) && MEM_aluout[0]);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = MEM_rs2data;
        case (size)
            SZ_HALF: begin
                be_c    = MEM_aluout[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{MEM_rs2data[15:0]}};
            end
            SZ_BYTE: begin
                be_c    = 4'b0001 << MEM_aluout[1:0];
                wdata_c = {4{MEM_rs2data[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        start        = 1'b0;
        mem_stall    = 1'b0;
        misalign_exc = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else if (!INT_detected) begin
                        start     = 1'b1;
                        mem_stall = 1'b1;
                        state_nx  = REQ;
                    end
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dm_ack || timeout_hit) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs, wait counter, captured load data and timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'h0;
            dm_be    <= 4'h0;
            dm_wdata <= 32'h0;
            type_q   <= 3'b000;
            lo_q     <= 2'b00;
            cnt      <= '0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dm_req   <= 1'b1;
                        dm_we    <= MEM_MemWrite;
                        dm_addr  <= {MEM_aluout[31:2], 2'b00};
                        dm_be    <= be_c;
                        dm_wdata <= wdata_c;
                        type_q   <= MEM_DMType;
                        lo_q     <= MEM_aluout[1:0];
                        cnt      <= '0;
                        err_q    <= 1'b0;
                        data_q   <= 32'h0;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        data_q <= dm_we ? 32'h0 : fmt_load(type_q, lo_q, dm_rdata);
                    end else if (timeout_hit) begin
                        dm_req <= 1'b0;
                        data_q <= 32'h0;
                        err_q  <= 1'b1;
                    end
                end
                DONE: begin
                    err_q  <= 1'b0;
                    data_q <= 32'h0;
                end
                default: ;
            endcase
        end
    end

    assign MEM_Data_in = (state == DONE) ? data_q : 32'h0;
    assign bus_err     = (state == DONE) & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboarded load data, bus shape,
// stall length, misalignment, timeout, reset and interrupt blocking.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_valid, MEM_MemRead, MEM_MemWrite, INT_detected;
    logic [2:0]  MEM_DMType;
    logic [31:0] MEM_aluout, MEM_rs2data;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, MEM_Data_in;
    logic [3:0]  dm_be;
    logic        mem_stall, misalign_exc, bus_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .MEM_valid(MEM_valid), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_DMType(MEM_DMType), .MEM_aluout(MEM_aluout), .MEM_rs2data(MEM_rs2data),
        .INT_detected(INT_detected),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .MEM_Data_in(MEM_Data_in), .mem_stall(mem_stall),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_valid    = 1'b0;
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        MEM_DMType   = 3'b000;
        MEM_aluout   = 32'h0;
        MEM_rs2data  = 32'h0;
    endtask

    // One complete access; ack_at = REQ cycle index of the ack, -1 for never.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rword, input int ack_at,
                             input logic [31:0] exp_data, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic exp_err);
        int req_cycles;
        int stall_cycles;
        int exp_req;
        logic bus_ok;
        logic [31:0] exp_q;
        exp_req      = (ack_at < 0) ? 16 : ack_at + 1;
        MEM_valid    = 1'b1;
        MEM_MemRead  = ~wr;
        MEM_MemWrite = wr;
        MEM_DMType   = t;
        MEM_aluout   = a;
        MEM_rs2data  = wd;
        #1;
        chk1({tag, "_stall_idle"}, mem_stall, 1'b1);
        chk1({tag, "_req_idle"}, dm_req, 1'b0);
        sb.push_back(exp_data);
        stall_cycles = 1;
        req_cycles   = 0;
        bus_ok       = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!dm_req) break;
            req_cycles++;
            if (mem_stall) stall_cycles++;
            if (dm_we !== wr || dm_addr !== {a[31:2], 2'b00} || dm_be !== exp_be ||
                dm_wdata !== exp_wdata || MEM_Data_in !== 32'h0)
                bus_ok = 1'b0;
            dm_ack   = (req_cycles - 1 == ack_at);
            dm_rdata = dm_ack ? rword : 32'h5A5A_5A5A;
        end
        dm_ack = 1'b0;
        #1;
        chk1({tag, "_bus_stable"}, bus_ok, 1'b1);
        chk32({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_req));
        chk32({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_req + 1));
        chk1({tag, "_stall_done"}, mem_stall, 1'b0);
        exp_q = (sb.size() != 0) ? sb.pop_front() : 32'hBAD0_BAD0;
        chk32({tag, "_data"}, MEM_Data_in, exp_q);
        chk1({tag, "_bus_err"}, bus_err, exp_err);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk32({tag, "_data_idle"}, MEM_Data_in, 32'h0);
        chk1({tag, "_err_idle"}, bus_err, 1'b0);
        chk1({tag, "_req_after"}, dm_req, 1'b0);
    endtask

    task automatic do_misaligned(input string tag, input logic wr, input logic [2:0] t,
                                 input logic [31:0] a);
        MEM_valid    = 1'b1;
        MEM_MemRead  = ~wr;
        MEM_MemWrite = wr;
        MEM_DMType   = t;
        MEM_aluout   = a;
        MEM_rs2data  = 32'h1234_5678;
        #1;
        chk1({tag, "_exc"}, misalign_exc, 1'b1);
        chk1({tag, "_stall"}, mem_stall, 1'b0);
        chk32({tag, "_data"}, MEM_Data_in, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            chk1({tag, "_no_req"}, dm_req, 1'b0);
        end
        idle_inputs();
    endtask

    initial begin
        reset        = 1'b1;
        INT_detected = 1'b0;
        dm_ack       = 1'b0;
        dm_rdata     = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", dm_req, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk32("rst_data", MEM_Data_in, 32'h0);
        chk1("rst_err", bus_err, 1'b0);
        chk32("rst_addr", dm_addr, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_access("lw",  1'b0, 3'b000, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
                  32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        do_access("lb",  1'b0, 3'b011, 32'h103, 32'h0, 32'h8011_2233, 0,
                  32'hFFFF_FF80, 4'b1000, 32'h0, 1'b0);
        do_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 0,
                  32'h0000_0080, 4'b1000, 32'h0, 1'b0);
        do_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h8011_2233, 0,
                  32'hFFFF_8011, 4'b1100, 32'h0, 1'b0);
        do_access("sb",  1'b1, 3'b011, 32'h201, 32'h0000_00AB, 32'hFFFF_FFFF, 3,
                  32'h0, 4'b0010, 32'hABAB_ABAB, 1'b0);
        do_access("sh",  1'b1, 3'b001, 32'h202, 32'h1234_CDEF, 32'hFFFF_FFFF, 1,
                  32'h0, 4'b1100, 32'hCDEF_CDEF, 1'b0);

        do_misaligned("mis_lw", 1'b0, 3'b000, 32'h102);
        do_misaligned("mis_sh", 1'b1, 3'b001, 32'h101);

        do_access("tmo", 1'b0, 3'b000, 32'h600, 32'h0, 32'hDEAD_BEEF, -1,
                  32'h0, 4'b1111, 32'h0, 1'b1);

        // Reset in the second REQ cycle, then a stray ack.
        MEM_valid   = 1'b1;
        MEM_MemRead = 1'b1;
        MEM_aluout  = 32'h300;
        @(posedge clk); #1;
        chk1("mid_req1", dm_req, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        #1;
        chk1("mid_rst_req", dm_req, 1'b0);
        chk1("mid_rst_stall", mem_stall, 1'b0);
        chk32("mid_rst_addr", dm_addr, 32'h0);
        @(posedge clk); #1;
        reset    = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk1("late_ack_req", dm_req, 1'b0);
        chk32("late_ack_data", MEM_Data_in, 32'h0);
        chk1("late_ack_err", bus_err, 1'b0);

        // Interrupt blocks a new load in IDLE.
        MEM_valid    = 1'b1;
        MEM_MemRead  = 1'b1;
        MEM_aluout   = 32'h400;
        INT_detected = 1'b1;
        #1;
        chk1("int_stall", mem_stall, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk1("int_no_req", dm_req, 1'b0);
        end
        INT_detected = 1'b0;
        idle_inputs();
        @(posedge clk); #1;

        do_access("lhu", 1'b0, 3'b010, 32'h500, 32'h0, 32'h8001_7FFF, 2,
                  32'h0000_7FFF, 4'b0011, 32'h0, 1'b0);

        chk32("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the address (ALU result), store data and access type for the instruction in MEM, and runs a request/acknowledge transaction on the data-memory bus.
- Stalls the pipeline while the transaction is outstanding.
- Delivers the formatted (sign- or zero-extended) load data as MEM_Data_in.

Parameters:
TIMEOUT, 16, REQ-state cycles without dm_ack before the access is abandoned with bus_err (legal range 2..255)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
MEM_valid  input  1  the MEM-stage instruction is valid (not a bubble)
MEM_MemRead  input  1  instruction is a load
MEM_MemWrite  input  1  instruction is a store
MEM_DMType  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; stores use 000, 001 or 011; other codes are treated as word
MEM_aluout  input  32  byte address
MEM_rs2data  input  32  store data
INT_detected  input  1  interrupt taken this cycle; blocks new accesses
dm_req  output  1  bus request, registered
dm_we  output  1  1 = write
dm_addr  output  32  word address, i.e. {addr[31:2], 2'b00}
dm_be  output  4  byte enables
dm_wdata  output  32  store data replicated into the selected lanes
dm_ack  input  1  single-cycle acknowledge; dm_rdata is valid in the same cycle
dm_rdata  input  32  read word
MEM_Data_in  output  32  formatted load data
mem_stall  output  1  freeze the PC and all registers before MEM/WB; insert a bubble into MEM/WB
misalign_exc  output  1  misaligned access detected (combinational)
bus_err  output  1  one-cycle pulse when an access times out

Behaviour:
- access = MEM_valid & (MEM_MemRead | MEM_MemWrite). If both read and write are set, the access is a write.
- misaligned conditions:
  - word access with addr[1:0] != 0
  - half access with addr[0] != 0
- FSM states are IDLE, REQ and DONE; the state is IDLE at reset.
- IDLE:
  - If access & !misaligned & !INT_detected: mem_stall = 1 (combinational), and on the next edge go to REQ, latching dm_we, dm_addr, dm_be, dm_wdata, the DMType and addr[1:0], and setting dm_req = 1.
  - If access & misaligned: misalign_exc = 1, mem_stall = 0, no request, MEM_Data_in = 0.
  - If access & INT_detected: no request and no stall.
- REQ:
  - dm_req and all bus outputs are held stable; mem_stall = 1.
  - The cycle counter clears on entry and increments every REQ cycle.
  - When dm_ack = 1: capture the formatted dm_rdata (loads only; 0 for stores), then go to DONE.
  - When the counter reaches TIMEOUT - 1 with no ack: go to DONE, capture data 0, set the error flag.
  - dm_req drops on the edge that leaves REQ.
  - INT_detected is ignored in REQ; bus transactions always complete.
- DONE:
  - mem_stall = 0 and MEM_Data_in = captured value for exactly one cycle; bus_err = error flag.
  - On the next edge go to IDLE and clear the flag. The pipeline advances at that edge, so the same instruction is never re-issued.
- Latency with immediate ack: stall in cycle 0 (IDLE) and cycle 1 (REQ); data is presented in cycle 2 (DONE). Each extra wait cycle adds one stall cycle.
- Load formatting uses the latched addr[1:0]:
  - byte = lane addr[1:0]
  - half = lane pair addr[1]
  - signed types sign-extend; unsigned types zero-extend; word passes through.
- Store byte enables:
  - word: 1111
  - half: 0011 or 1100
  - byte: one-hot 1 << addr[1:0]
- dm_wdata lane replication:
  - byte: {4{rs2[7:0]}}
  - half: {2{rs2[15:0]}}
- MEM_Data_in is 0 in every state other than DONE.
- Reset (including mid-transaction) takes effect immediately:
  - state IDLE
  - dm_req, dm_we, dm_addr, dm_be, dm_wdata = 0
  - captured data 0, counter 0, error flag 0
  - hence mem_stall, bus_err, MEM_Data_in = 0 unless a new access is presented in IDLE
- A late dm_ack that arrives outside REQ is ignored.

Test Plan:
- lw, addr 0x100, ack in the first REQ cycle, dm_rdata 0xDEADBEEF -> dm_req high 1 cycle, dm_addr 0x100, dm_be 1111, stall 2 cycles, MEM_Data_in 0xDEADBEEF in DONE.
- lb at 0x103 / lbu at 0x103, dm_rdata 0x80112233 -> MEM_Data_in 0xFFFFFF80 / 0x00000080; lh at 0x102 on the same word -> 0xFFFF8011.
- sb, rs2 0x000000AB, addr 0x201, ack after 3 wait cycles -> dm_we 1, dm_be 0010, dm_wdata 0xABABABAB, bus held 4 REQ cycles, stall 5 cycles, MEM_Data_in 0.
- lw at 0x102 and sh at 0x101 -> misalign_exc 1, dm_req never asserted, mem_stall 0.
- TIMEOUT = 16 with ack never asserted -> dm_req high 16 cycles, then one DONE cycle with bus_err 1 and MEM_Data_in 0, back to IDLE.
- reset asserted in the 2nd REQ cycle -> dm_req 0 immediately, state IDLE; a later dm_ack is ignored; INT_detected with a load in IDLE -> no request.
